// File: rtl/shared_buffer_banked.sv
// Dual-port shared buffer split into word-interleaved banks. Per-bank round-robin
// arbitration, byte-masked writes, registered read data with a valid strobe.
module shared_buffer_banked #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RETN,
    input  logic                P0_CEN,
    input  logic                P0_WEN,
    input  logic [ADDR_W-1:0]   P0_A,
    input  logic [DATA_W-1:0]   P0_D,
    input  logic [DATA_W/8-1:0] P0_BWEN,
    output logic                P0_GNT,
    output logic [DATA_W-1:0]   P0_Q,
    output logic                P0_QVLD,
    input  logic                P1_CEN,
    input  logic                P1_WEN,
    input  logic [ADDR_W-1:0]   P1_A,
    input  logic [DATA_W-1:0]   P1_D,
    input  logic [DATA_W/8-1:0] P1_BWEN,
    output logic                P1_GNT,
    output logic [DATA_W-1:0]   P1_Q,
    output logic                P1_QVLD,
    output logic [CNT_W-1:0]    CONF_CNT
);

    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned ROW_W  = ADDR_W - BANK_W;
    localparam int unsigned DEPTH  = 1 << ROW_W;
    localparam int unsigned NBYTES = DATA_W / 8;

    logic [DATA_W-1:0]    mem [NUM_BANKS][DEPTH];
    logic [NUM_BANKS-1:0] ptr;

    logic              acc_en;
    logic              req0, req1, conflict;
    logic [BANK_W-1:0] bank0, bank1;
    logic [ROW_W-1:0]  row0, row1;

    assign bank0 = P0_A[BANK_W-1:0];
    assign bank1 = P1_A[BANK_W-1:0];
    assign row0  = P0_A[ADDR_W-1:BANK_W];
    assign row1  = P1_A[ADDR_W-1:BANK_W];

    // Arbitration: a same-bank collision is won by the port the bank pointer names.
    always_comb begin
        acc_en   = ~RST & RETN;
        req0     = acc_en & ~P0_CEN;
        req1     = acc_en & ~P1_CEN;
        conflict = req0 & req1 & (bank0 == bank1);
        P0_GNT   = req0 & (~conflict | ~ptr[bank0]);
        P1_GNT   = req1 & (~conflict | ptr[bank1]);
    end

    // Pointer moves to the loser, so the next collision on that bank goes the other way.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr      <= '0;
            CONF_CNT <= '0;
        end else if (conflict) begin
            ptr[bank0] <= ~ptr[bank0];
            if (CONF_CNT != {CNT_W{1'b1}}) begin
                CONF_CNT <= CONF_CNT + CNT_W'(1);
            end
        end
    end

    // Storage is never reset; granted ports always hit different banks.
    always_ff @(posedge CLK) begin
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (P0_GNT && !P0_WEN && !P0_BWEN[b]) begin
                mem[bank0][row0][8*b +: 8] <= P0_D[8*b +: 8];
            end
            if (P1_GNT && !P1_WEN && !P1_BWEN[b]) begin
                mem[bank1][row1][8*b +: 8] <= P1_D[8*b +: 8];
            end
        end
    end

    // Read data is zero whenever the valid strobe is low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            P0_Q    <= '0;
            P0_QVLD <= 1'b0;
            P1_Q    <= '0;
            P1_QVLD <= 1'b0;
        end else begin
            P0_Q    <= '0;
            P0_QVLD <= 1'b0;
            P1_Q    <= '0;
            P1_QVLD <= 1'b0;
            if (P0_GNT && P0_WEN) begin
                P0_Q    <= mem[bank0][row0];
                P0_QVLD <= 1'b1;
            end
            if (P1_GNT && P1_WEN) begin
                P1_Q    <= mem[bank1][row1];
                P1_QVLD <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shared_buffer_banked.sv
// Bench for shared_buffer_banked: directed plan steps plus random traffic against
// a word-addressed reference model; a small second instance checks counter saturation.
module tb_shared_buffer_banked;

    localparam int unsigned DW   = 128;
    localparam int unsigned AW   = 13;
    localparam int unsigned NB   = 4;
    localparam int unsigned NBY  = DW / 8;
    localparam int          CMAX = 65535;

    logic CLK;
    logic rst, retn;
    logic cen0, wen0, cen1, wen1;
    logic [AW-1:0]  a0, a1;
    logic [DW-1:0]  d0, d1;
    logic [NBY-1:0] bwen0, bwen1;
    logic           gnt0, gnt1, qv0, qv1;
    logic [DW-1:0]  q0, q1;
    logic [15:0]    cnt;

    logic s_rst, s_cen0, s_cen1, s_wen;
    logic [3:0]  s_a0, s_a1;
    logic [15:0] s_d;
    logic [1:0]  s_bwen;
    logic        s_g0, s_g1, s_qv0, s_qv1;
    logic [15:0] s_q0, s_q1;
    logic [1:0]  s_cnt;

    int tests = 0;
    int fails = 0;

    shared_buffer_banked dut (
        .CLK(CLK), .RST(rst), .RETN(retn),
        .P0_CEN(cen0), .P0_WEN(wen0), .P0_A(a0), .P0_D(d0), .P0_BWEN(bwen0),
        .P0_GNT(gnt0), .P0_Q(q0), .P0_QVLD(qv0),
        .P1_CEN(cen1), .P1_WEN(wen1), .P1_A(a1), .P1_D(d1), .P1_BWEN(bwen1),
        .P1_GNT(gnt1), .P1_Q(q1), .P1_QVLD(qv1),
        .CONF_CNT(cnt)
    );

    shared_buffer_banked #(.DATA_W(16), .ADDR_W(4), .NUM_BANKS(2), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(s_rst), .RETN(1'b1),
        .P0_CEN(s_cen0), .P0_WEN(s_wen), .P0_A(s_a0), .P0_D(s_d), .P0_BWEN(s_bwen),
        .P0_GNT(s_g0), .P0_Q(s_q0), .P0_QVLD(s_qv0),
        .P1_CEN(s_cen1), .P1_WEN(s_wen), .P1_A(s_a1), .P1_D(s_d), .P1_BWEN(s_bwen),
        .P1_GNT(s_g1), .P1_Q(s_q1), .P1_QVLD(s_qv1),
        .CONF_CNT(s_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: flat word memory, per-word "written in full" flag, bank owners.
    logic [DW-1:0] mm [1 << AW];
    bit            known [1 << AW];
    bit            mptr [NB];
    int            mcnt;
    logic [DW-1:0] eq0, eq1;
    bit            eqv0, eqv1, ek0, ek1;
    bit            m_e0, m_e1;

    logic          g0_obs, g1_obs, qv0_obs, qv1_obs;
    logic [DW-1:0] q0_obs, q1_obs;
    logic [15:0]   cnt_obs;

    localparam logic [DW-1:0] PAT = {32{4'h1}};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NBY-1:0] bw);
        for (int i = 0; i < int'(NBY); i++) begin
            if (!bw[i]) mm[a][8*i +: 8] = d[8*i +: 8];
        end
        if (bw == '0) known[a] = 1'b1;
    endtask

    // One clock cycle: inputs already set after the previous edge; sample and
    // compare on the falling edge, advance the model, then move past the next edge.
    task automatic tick();
        bit en, r0, r1, c, e0, e1, nv0, nv1, nk0, nk1;
        int bk0, bk1;
        logic [DW-1:0] nq0, nq1;
        @(negedge CLK);
        #1;
        g0_obs = gnt0; g1_obs = gnt1; q0_obs = q0; q1_obs = q1;
        qv0_obs = qv0; qv1_obs = qv1; cnt_obs = cnt;
        en  = !rst && retn;
        r0  = en && !cen0;
        r1  = en && !cen1;
        bk0 = int'(a0) % NB;
        bk1 = int'(a1) % NB;
        c   = r0 && r1 && (bk0 == bk1);
        if (c) begin
            e0 = !mptr[bk0];
            e1 = mptr[bk0];
        end else begin
            e0 = r0;
            e1 = r1;
        end
        check("p0_gnt", 128'(g0_obs), 128'(e0));
        check("p1_gnt", 128'(g1_obs), 128'(e1));
        check("p0_qvld", 128'(qv0_obs), 128'(eqv0));
        check("p1_qvld", 128'(qv1_obs), 128'(eqv1));
        if (ek0) check("p0_q", q0_obs, eq0);
        if (ek1) check("p1_q", q1_obs, eq1);
        check("conf_cnt", 128'(cnt_obs), 128'(mcnt));
        if (c) begin
            mptr[bk0] = !mptr[bk0];
            if (mcnt < CMAX) mcnt++;
        end
        nq0 = '0; nv0 = 1'b0; nk0 = 1'b1;
        nq1 = '0; nv1 = 1'b0; nk1 = 1'b1;
        if (e0 && wen0) begin nq0 = mm[a0]; nv0 = 1'b1; nk0 = known[a0]; end
        if (e1 && wen1) begin nq1 = mm[a1]; nv1 = 1'b1; nk1 = known[a1]; end
        if (e0 && !wen0) model_write(a0, d0, bwen0);
        if (e1 && !wen1) model_write(a1, d1, bwen1);
        if (rst) begin
            for (int i = 0; i < int'(NB); i++) mptr[i] = 1'b0;
            mcnt = 0;
        end
        eq0 = nq0; eqv0 = nv0; ek0 = nk0;
        eq1 = nq1; eqv1 = nv1; ek1 = nk1;
        m_e0 = e0; m_e1 = e1;
        @(posedge CLK);
        #1;
    endtask

    task automatic gen(output logic cen, output logic wen, output logic [AW-1:0] a,
                       output logic [DW-1:0] d, output logic [NBY-1:0] bw);
        cen = ($urandom_range(0, 3) == 0);
        wen = 1'($urandom_range(0, 1));
        a   = AW'($urandom_range(0, 15));
        d   = rnd128();
        bw  = ($urandom_range(0, 1) == 0) ? '0 : NBY'($urandom);
    endtask

    initial begin
        rst = 1'b1; retn = 1'b1;
        cen0 = 1'b0; wen0 = 1'b1; a0 = '0; d0 = '0; bwen0 = '1;
        cen1 = 1'b0; wen1 = 1'b1; a1 = AW'(1); d1 = '0; bwen1 = '1;
        s_rst = 1'b1; s_cen0 = 1'b1; s_cen1 = 1'b1; s_wen = 1'b1;
        s_a0 = 4'd0; s_a1 = 4'd2; s_d = '0; s_bwen = '1;
        for (int i = 0; i < (1 << AW); i++) known[i] = 1'b0;
        for (int i = 0; i < int'(NB); i++) mptr[i] = 1'b0;
        mcnt = 0; eq0 = '0; eq1 = '0; eqv0 = 1'b0; eqv1 = 1'b0; ek0 = 1'b1; ek1 = 1'b1;
        m_e0 = 1'b0; m_e1 = 1'b0;
        @(posedge CLK);
        #1;

        // Reset held with both ports requesting
        repeat (3) begin
            tick();
            check("rst_gnt0", 128'(g0_obs), 128'(0));
            check("rst_gnt1", 128'(g1_obs), 128'(0));
        end
        rst = 1'b0; cen0 = 1'b1; cen1 = 1'b1;
        tick();
        check("rst_q0", q0_obs, '0);
        check("rst_qvld1", 128'(qv1_obs), 128'(0));
        check("rst_cnt", 128'(cnt_obs), 128'(0));

        // Write on P0, read back on P1
        cen0 = 1'b0; wen0 = 1'b0; a0 = AW'(5); d0 = PAT; bwen0 = '0;
        tick();
        cen0 = 1'b1; cen1 = 1'b0; wen1 = 1'b1; a1 = AW'(5);
        tick();
        check("wr_rd_gnt1", 128'(g1_obs), 128'(1));
        cen1 = 1'b1;
        tick();
        check("wr_rd_q1", q1_obs, PAT);
        check("wr_rd_qvld1", 128'(qv1_obs), 128'(1));

        // Byte-masked overwrite of the low four bytes
        cen0 = 1'b0; wen0 = 1'b0; a0 = AW'(16); d0 = '1; bwen0 = '0;
        tick();
        d0 = '0; bwen0 = 16'hFFF0;
        tick();
        wen0 = 1'b1;
        tick();
        cen0 = 1'b1;
        tick();
        check("bmask_q0", q0_obs, {{96{1'b1}}, 32'h0});

        cen0 = 1'b0; wen0 = 1'b0; a0 = AW'(1); d0 = rnd128(); bwen0 = '0;
        tick();

        // Conflict on bank 1: P0 wins first
        wen0 = 1'b1; a0 = AW'(1); cen1 = 1'b0; wen1 = 1'b1; a1 = AW'(5);
        tick();
        check("conf1_gnt0", 128'(g0_obs), 128'(1));
        check("conf1_gnt1", 128'(g1_obs), 128'(0));
        cen0 = 1'b1;
        tick();
        check("conf1_gnt1_late", 128'(g1_obs), 128'(1));
        cen1 = 1'b1;
        tick();
        check("conf1_cnt", 128'(cnt_obs), 128'(1));

        // Same conflict again: P1 now holds priority
        cen0 = 1'b0; cen1 = 1'b0;
        tick();
        check("conf2_gnt0", 128'(g0_obs), 128'(0));
        check("conf2_gnt1", 128'(g1_obs), 128'(1));
        cen1 = 1'b1;
        tick();
        check("conf2_gnt0_late", 128'(g0_obs), 128'(1));
        cen0 = 1'b1;
        tick();
        check("conf2_cnt", 128'(cnt_obs), 128'(2));

        // Different banks in the same cycle
        cen0 = 1'b0; wen0 = 1'b0; a0 = AW'(2); d0 = rnd128(); bwen0 = '0;
        cen1 = 1'b0; wen1 = 1'b0; a1 = AW'(3); d1 = rnd128(); bwen1 = '0;
        tick();
        check("noconf_gnt0", 128'(g0_obs), 128'(1));
        check("noconf_gnt1", 128'(g1_obs), 128'(1));
        cen0 = 1'b1; cen1 = 1'b1;
        tick();
        check("noconf_cnt", 128'(cnt_obs), 128'(2));

        // Retention blocks access but keeps contents
        retn = 1'b0;
        cen0 = 1'b0; wen0 = 1'b1; a0 = AW'(5); cen1 = 1'b0; wen1 = 1'b1; a1 = AW'(5);
        tick();
        check("ret_gnt0", 128'(g0_obs), 128'(0));
        check("ret_gnt1", 128'(g1_obs), 128'(0));
        tick();
        check("ret_q0", q0_obs, '0);
        check("ret_q1", q1_obs, '0);
        retn = 1'b1; cen1 = 1'b1;
        tick();
        check("ret_gnt0_after", 128'(g0_obs), 128'(1));
        cen0 = 1'b1;
        tick();
        check("ret_q0_after", q0_obs, PAT);

        // Reset during a stall drops the request and reverts the pointer
        cen0 = 1'b0; a0 = AW'(1); cen1 = 1'b0; a1 = AW'(5);
        tick();
        check("rstall_gnt1", 128'(g1_obs), 128'(0));
        cen0 = 1'b1; rst = 1'b1;
        tick();
        check("rstall_rst_gnt1", 128'(g1_obs), 128'(0));
        rst = 1'b0; cen0 = 1'b0;
        tick();
        check("rstall_ptr_gnt0", 128'(g0_obs), 128'(1));
        check("rstall_ptr_gnt1", 128'(g1_obs), 128'(0));
        cen0 = 1'b1;
        tick();
        cen1 = 1'b1;
        tick();
        check("rstall_cnt", 128'(cnt_obs), 128'(1));

        // Random traffic on a small address window to force frequent collisions
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 63) == 0);
            retn = ($urandom_range(0, 19) != 0);
            if (cen0 || m_e0) gen(cen0, wen0, a0, d0, bwen0);
            if (cen1 || m_e1) gen(cen1, wen1, a1, d1, bwen1);
            tick();
        end
        rst = 1'b0; retn = 1'b1; cen0 = 1'b1; cen1 = 1'b1;
        tick();

        // Counter saturation on the 2-bit instance: continuous same-bank collisions
        s_rst = 1'b0; s_cen0 = 1'b0; s_cen1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK);
            #1;
            check("sat_cnt", 128'(s_cnt), 128'((k < 3) ? k : 3));
            check("sat_one_gnt", 128'(s_g0 ^ s_g1), 128'(1));
        end
        s_cen0 = 1'b1; s_cen1 = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
